// File: rtl/reset_hold_pkg.sv
// Shared state encodings and default thresholds for the reset hold timer.
package reset_hold_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1,
    ST_OFF  = 2'd2,
    ST_CLR  = 2'd3
  } hold_state_e;

  localparam int DEF_CLK_HZ    = 7093790;
  localparam int DEF_TICK_HZ   = 10;
  localparam int DEF_OFF_TICKS = 30;
  localparam int DEF_RST_TICKS = 60;
  localparam int DEF_FILT      = 4;

  // Bits needed to hold values 0..max_val, never less than one.
  function automatic int cnt_w(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/reset_hold_timer_tick_gen.sv
// Prescaler: counts 0..DIV-1 while enabled and flags the wrap cycle as a tick.
module tick_gen
  import reset_hold_pkg::*;
#(
  parameter int DIV = 10
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int W = cnt_w(DIV - 1);
  localparam logic [W-1:0] LAST = W'(DIV - 1);
  localparam logic [W-1:0] ONE  = W'(1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       cnt <= '0;
    else if (clr)     cnt <= '0;
    else if (en)      cnt <= (cnt == LAST) ? '0 : cnt + ONE;
  end

  assign tick = en && !clr && (cnt == LAST);

endmodule

// File: rtl/reset_hold_timer.sv
// Times how long the bus reset is held and raises maprom-off / maprom-clear levels.
module reset_hold_timer
  import reset_hold_pkg::*;
#(
  parameter int CLK_HZ    = DEF_CLK_HZ,
  parameter int TICK_HZ   = DEF_TICK_HZ,
  parameter int OFF_TICKS = DEF_OFF_TICKS,
  parameter int RST_TICKS = DEF_RST_TICKS,
  parameter int FILT      = DEF_FILT
) (
  input  logic       CLK,
  input  logic       _POR,
  input  logic       _RST,
  output logic       rst_maprom_off,
  output logic       rst_maprom_rst,
  output logic [1:0] hold_state
);

  localparam int DIV = (CLK_HZ / TICK_HZ < 1) ? 1 : CLK_HZ / TICK_HZ;
  localparam int FW  = cnt_w(FILT);
  localparam int TW  = cnt_w(RST_TICKS);

  localparam logic [FW-1:0] FILT_MAX = FW'(FILT);
  localparam logic [TW-1:0] OFF_MAX  = TW'(OFF_TICKS);
  localparam logic [TW-1:0] RST_MAX  = TW'(RST_TICKS);

  logic [1:0]    sync;
  logic          rst_s;
  logic [FW-1:0] filt_cnt, filt_nx;
  logic [TW-1:0] tick_cnt;
  logic          tick, enter, run_en;
  hold_state_e   state;

  always_ff @(posedge CLK or negedge _POR) begin
    if (!_POR) sync <= 2'b11;
    else       sync <= {sync[0], _RST};
  end
  assign rst_s = sync[1];

  always_comb begin
    filt_nx = filt_cnt;
    if (rst_s)                     filt_nx = '0;
    else if (filt_cnt != FILT_MAX) filt_nx = filt_cnt + FW'(1);
  end

  always_ff @(posedge CLK or negedge _POR) begin
    if (!_POR) filt_cnt <= '0;
    else       filt_cnt <= filt_nx;
  end

  // Hold starts on the very edge the filter saturates.
  assign enter  = (state == ST_IDLE) && !rst_s && (filt_nx == FILT_MAX);
  assign run_en = (state == ST_HOLD) || (state == ST_OFF);

  tick_gen #(.DIV(DIV)) u_tick_gen (
    .clk   (CLK),
    .rst_n (_POR),
    .en    (run_en),
    .clr   (enter),
    .tick  (tick)
  );

  always_ff @(posedge CLK or negedge _POR) begin
    if (!_POR)                           tick_cnt <= '0;
    else if (enter)                      tick_cnt <= '0;
    else if (tick && tick_cnt != RST_MAX) tick_cnt <= tick_cnt + TW'(1);
  end

  // Release always wins over any threshold hit in the same cycle.
  always_ff @(posedge CLK or negedge _POR) begin
    if (!_POR) begin
      state          <= ST_IDLE;
      rst_maprom_off <= 1'b0;
      rst_maprom_rst <= 1'b0;
    end else if (state != ST_IDLE && rst_s) begin
      state          <= ST_IDLE;
      rst_maprom_off <= 1'b0;
      rst_maprom_rst <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: if (enter) state <= ST_HOLD;
        ST_HOLD: if (tick_cnt >= OFF_MAX) begin
          state          <= ST_OFF;
          rst_maprom_off <= 1'b1;
        end
        ST_OFF:  if (tick_cnt == RST_MAX) begin
          state          <= ST_CLR;
          rst_maprom_rst <= 1'b1;
        end
        default: state <= ST_CLR;
      endcase
    end
  end

  assign hold_state = state;

endmodule

// File: tb/tb_reset_hold_timer.sv
// Scoreboard bench: a run-length model of the held reset predicts every cycle's outputs.
module tb_reset_hold_timer;

  localparam int CLK_HZ    = 1000;
  localparam int TICK_HZ   = 100;
  localparam int OFF_TICKS = 3;
  localparam int RST_TICKS = 6;
  localparam int FILT      = 4;
  localparam int P         = CLK_HZ / TICK_HZ;
  // Consecutive low rst_s samples needed for each state; thresholds act one cycle late.
  localparam int N_OFF     = FILT + OFF_TICKS * P + 1;
  localparam int N_CLR     = FILT + RST_TICKS * P + 1;

  logic       clk = 1'b0;
  logic       por_n, rst_bus_n;
  logic       off, clr;
  logic [1:0] hs;

  typedef struct packed {
    logic [1:0] st;
    logic       off;
    logic       clr;
  } exp_t;

  exp_t sb[$];
  int   compared   = 0;
  int   mismatched = 0;
  int   cyc        = 0;

  logic m_s1 = 1'b1, m_s2 = 1'b1;
  int   m_run = 0;

  always #5 clk = ~clk;

  reset_hold_timer #(
    .CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ), .OFF_TICKS(OFF_TICKS),
    .RST_TICKS(RST_TICKS), .FILT(FILT)
  ) dut (
    .CLK            (clk),
    ._POR           (por_n),
    ._RST           (rst_bus_n),
    .rst_maprom_off (off),
    .rst_maprom_rst (clr),
    .hold_state     (hs)
  );

  function automatic exp_t predict(input int run);
    exp_t e;
    if (run < FILT)       e.st = 2'd0;
    else if (run < N_OFF) e.st = 2'd1;
    else if (run < N_CLR) e.st = 2'd2;
    else                  e.st = 2'd3;
    e.off = (e.st >= 2'd2);
    e.clr = (e.st == 2'd3);
    return e;
  endfunction

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s cycle %0d: got %0d expected %0d", name, cyc, got, exp);
    end
  endtask

  task automatic step(input logic r, input logic p);
    logic fell;
    @(negedge clk);
    #1;
    fell      = por_n && !p;
    por_n     = p;
    rst_bus_n = r;
    if (fell) begin
      #1;
      check("por_async_state", {6'd0, hs}, 8'd0);
      check("por_async_off",   {7'd0, off}, 8'd0);
      check("por_async_clr",   {7'd0, clr}, 8'd0);
    end
    @(posedge clk);
    cyc++;
    if (!p) begin
      m_s1 = 1'b1; m_s2 = 1'b1; m_run = 0;
    end else begin
      m_run = m_s2 ? 0 : m_run + 1;
      m_s2  = m_s1;
      m_s1  = r;
    end
    sb.push_back(predict(m_run));
  endtask

  task automatic run(input logic r, input int n, input logic p = 1'b1);
    repeat (n) step(r, p);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check("hold_state",     {6'd0, hs},  {6'd0, e.st});
      check("rst_maprom_off", {7'd0, off}, {7'd0, e.off});
      check("rst_maprom_rst", {7'd0, clr}, {7'd0, e.clr});
    end
  end

  initial begin
    int hi, lo, kind, k;
    por_n     = 1'b0;
    rst_bus_n = 1'b1;
    run(1, 3, 0);
    run(1, 5);
    // short pulse, filter boundary, short hold
    run(0, 3);  run(1, 8);
    run(0, 4);  run(1, 8);
    run(0, 20); run(1, 8);
    // release racing the third tick, then one cycle longer
    run(0, N_OFF - 1); run(1, 8);
    run(0, N_OFF);     run(1, 8);
    // full hold into CLR, then release
    run(0, N_CLR + 20); run(1, 8);
    // power-on reset while in OFF restarts timing
    run(0, N_OFF + 10);
    run(0, 3, 0);
    run(0, N_CLR + 5);
    run(1, 8);
    // randomized segments with occasional power-on resets
    for (int i = 0; i < 60; i++) begin
      hi   = $urandom_range(1, 6);
      kind = $urandom_range(0, 3);
      case (kind)
        0:       lo = $urandom_range(1, 6);
        1:       lo = $urandom_range(20, 40);
        2:       lo = $urandom_range(30, 70);
        default: lo = $urandom_range(60, 90);
      endcase
      run(1, hi);
      if ($urandom_range(0, 7) == 0) begin
        k = $urandom_range(0, lo);
        run(0, k);
        run($urandom_range(0, 1), $urandom_range(1, 3), 0);
        run(0, lo - k);
      end else begin
        run(0, lo);
      end
    end
    run(1, 6);
    @(negedge clk);
    #3;
    check("scoreboard_drained", 8'(sb.size()), 8'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
